// File: rtl/riscv_multicycle_ctrl.sv
// riscv_multicycle_ctrl: multicycle RV32I control FSM driving datapath selects, ALUControl and a retire counter
module riscv_multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [6:0]       op_i,
  input  logic [2:0]       funct3_i,
  input  logic             funct7b5_i,
  input  logic             zero_i,
  output logic             pc_write_o,
  output logic             adr_src_o,
  output logic             mem_write_o,
  output logic             ir_write_o,
  output logic             reg_write_o,
  output logic [1:0]       result_src_o,
  output logic [1:0]       alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [1:0]       imm_src_o,
  output logic [2:0]       alu_control_o,
  output logic             illegal_o,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instr_ret_o
);
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pc_update, branch, mem_write, ir_write, reg_write, retire;
  logic [1:0]       alu_op;
  logic [2:0]       funct_ctrl;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = S_DECODE;
      S_DECODE:   state_d = (op_i == OP_LW || op_i == OP_SW) ? S_MEMADR :
                            (op_i == OP_R)   ? S_EXECUTER :
                            (op_i == OP_I)   ? S_EXECUTEI :
                            (op_i == OP_BEQ) ? S_BEQ :
                            (op_i == OP_JAL) ? S_JAL : S_FETCH;
      S_MEMADR:   state_d = op_i[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end
  // alu_op: 00 add, 01 sub, 10 decode from funct fields
  always_comb begin
    pc_update    = 1'b0;
    branch       = 1'b0;
    adr_src_o    = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    reg_write    = 1'b0;
    result_src_o = 2'b00;
    alu_src_a_o  = 2'b00;
    alu_src_b_o  = 2'b00;
    alu_op       = 2'b00;
    case (state_q)
      S_FETCH: begin
        ir_write     = 1'b1;
        alu_src_b_o  = 2'b10;
        result_src_o = 2'b10;
        pc_update    = 1'b1;
      end
      S_DECODE: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
      end
      S_MEMREAD:  adr_src_o = 1'b1;
      S_MEMWB: begin
        result_src_o = 2'b01;
        reg_write    = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src_o = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a_o = 2'b10;
        alu_op      = 2'b10;
      end
      S_EXECUTEI: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        alu_op      = 2'b10;
      end
      S_ALUWB:    reg_write = 1'b1;
      S_BEQ: begin
        alu_src_a_o = 2'b10;
        alu_op      = 2'b01;
        branch      = 1'b1;
      end
      S_JAL: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b10;
        pc_update   = 1'b1;
      end
      default: ;
    endcase
  end
  always_comb begin
    funct_ctrl = (funct3_i == 3'b000) ? ((op_i[5] & funct7b5_i) ? 3'b001 : 3'b000) :
                 (funct3_i == 3'b010) ? 3'b101 :
                 (funct3_i == 3'b110) ? 3'b011 :
                 (funct3_i == 3'b111) ? 3'b010 : 3'b000;
    alu_control_o = (alu_op == 2'b10) ? funct_ctrl : (alu_op == 2'b01) ? 3'b001 : 3'b000;
    imm_src_o = (op_i == OP_SW)  ? 2'b01 :
                (op_i == OP_BEQ) ? 2'b10 :
                (op_i == OP_JAL) ? 2'b11 : 2'b00;
    illegal_o = (state_q == S_DECODE) && (state_d == S_FETCH);
    retire = (state_q == S_MEMWB) || (state_q == S_MEMWRITE) || (state_q == S_ALUWB) ||
             (state_q == S_BEQ);
    cnt_d = retire ? cnt_q + 1'b1 : cnt_q;
  end
  // write enables must stay quiet for the whole time reset is held
  assign pc_write_o  = ~reset_i & (pc_update | (branch & zero_i));
  assign mem_write_o = ~reset_i & mem_write;
  assign ir_write_o  = ~reset_i & ir_write;
  assign reg_write_o = ~reset_i & reg_write;
  assign state_o     = state_q;
  assign instr_ret_o = cnt_q;
endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// tb_riscv_multicycle_ctrl: directed-vector bench for the multicycle control FSM (CNT_W=4 to exercise wrap)
module tb_riscv_multicycle_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [3:0] state, instr_ret;
  int         n_tests = 0, n_fail = 0;

  riscv_multicycle_ctrl #(.CNT_W(4)) dut (
    .clk_i(clk), .reset_i(reset), .op_i(op), .funct3_i(funct3), .funct7b5_i(funct7b5),
    .zero_i(zero), .pc_write_o(pc_write), .adr_src_o(adr_src), .mem_write_o(mem_write),
    .ir_write_o(ir_write), .reg_write_o(reg_write), .result_src_o(result_src),
    .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .imm_src_o(imm_src),
    .alu_control_o(alu_control), .illegal_o(illegal), .state_o(state), .instr_ret_o(instr_ret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic alu_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic [3:0] exec_st, input logic [2:0] ctrl, input logic [3:0] ret);
    op = o; funct3 = f3; funct7b5 = f7;
    chk("alu_fetch", state, 0);
    cyc(); chk("alu_decode", state, 1);
    cyc(); chk("alu_exec", state, exec_st); chk("alu_ctrl", alu_control, ctrl);
    chk("alu_srcb", alu_src_b, (exec_st == 7) ? 1 : 0);
    cyc(); chk("alu_wb", state, 8); chk("alu_wb_regw", reg_write, 1);
    cyc(); chk("alu_done", state, 0); chk("alu_ret", instr_ret, ret);
  endtask

  task automatic beq_instr(input logic z, input logic [3:0] ret);
    op = 7'b1100011; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
    chk("beq_fetch", state, 0);
    cyc(); chk("beq_decode", state, 1); chk("beq_imm", imm_src, 2);
    zero = z;
    cyc(); chk("beq_state", state, 9); chk("beq_pcw", pc_write, z); chk("beq_ctrl", alu_control, 1);
    cyc(); chk("beq_done", state, 0); chk("beq_ret", instr_ret, ret);
    zero = 1'b0;
  endtask

  initial begin
    reset = 1'b1; op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
    @(negedge clk);
    chk("rst_state", state, 0); chk("rst_irw", ir_write, 0); chk("rst_pcw", pc_write, 0);
    chk("rst_ret", instr_ret, 0); chk("rst_srcb", alu_src_b, 2); chk("rst_res", result_src, 2);
    reset = 1'b0;
    #1;
    chk("fetch_irw", ir_write, 1); chk("fetch_pcw", pc_write, 1);
    cyc(); chk("lw_s1", state, 1); chk("lw_irw1", ir_write, 0); chk("lw_srca1", alu_src_a, 1);
    cyc(); chk("lw_s2", state, 2); chk("lw_srca2", alu_src_a, 2); chk("lw_srcb2", alu_src_b, 1);
    cyc(); chk("lw_s3", state, 3); chk("lw_adr3", adr_src, 1); chk("lw_irw3", ir_write, 0);
    cyc(); chk("lw_s4", state, 4); chk("lw_regw4", reg_write, 1); chk("lw_res4", result_src, 1);
    cyc(); chk("lw_s0", state, 0); chk("lw_ret", instr_ret, 1);
    alu_instr(7'b0110011, 3'b000, 1'b0, 6, 3'b000, 2);
    alu_instr(7'b0110011, 3'b000, 1'b1, 6, 3'b001, 3);
    alu_instr(7'b0010011, 3'b000, 1'b1, 7, 3'b000, 4);
    alu_instr(7'b0010011, 3'b010, 1'b0, 7, 3'b101, 5);
    alu_instr(7'b0010011, 3'b110, 1'b0, 7, 3'b011, 6);
    alu_instr(7'b0010011, 3'b111, 1'b0, 7, 3'b010, 7);
    beq_instr(1'b1, 8);
    beq_instr(1'b0, 9);
    op = 7'b0100011;
    cyc(); chk("sw_s1", state, 1); chk("sw_imm", imm_src, 1);
    cyc(); chk("sw_s2", state, 2);
    cyc(); chk("sw_s5", state, 5); chk("sw_memw", mem_write, 1); chk("sw_adr", adr_src, 1);
    cyc(); chk("sw_s0", state, 0); chk("sw_ret", instr_ret, 10);
    op = 7'b1101111;
    cyc(); chk("jal_s1", state, 1); chk("jal_imm", imm_src, 3);
    cyc(); chk("jal_s10", state, 10); chk("jal_pcw", pc_write, 1);
    chk("jal_srca", alu_src_a, 1); chk("jal_srcb", alu_src_b, 2);
    cyc(); chk("jal_s8", state, 8); chk("jal_regw", reg_write, 1);
    cyc(); chk("jal_s0", state, 0); chk("jal_ret", instr_ret, 11);
    op = 7'b1111111;
    cyc(); chk("ill_s1", state, 1); chk("ill_flag", illegal, 1);
    cyc(); chk("ill_s0", state, 0); chk("ill_ret", instr_ret, 11); chk("ill_flag0", illegal, 0);
    beq_instr(1'b0, 12);
    beq_instr(1'b0, 13);
    beq_instr(1'b0, 14);
    beq_instr(1'b1, 15);
    beq_instr(1'b0, 0);
    beq_instr(1'b0, 1);
    op = 7'b0100011;
    cyc(); cyc(); cyc(); chk("rst_sw_s5", state, 5); chk("rst_sw_memw", mem_write, 1);
    reset = 1'b1;
    #1;
    chk("rst_mid_memw", mem_write, 0); chk("rst_mid_state", state, 0); chk("rst_mid_ret", instr_ret, 0);
    cyc();
    reset = 1'b0;
    #1;
    chk("rel_state", state, 0); chk("rel_ret", instr_ret, 0);
    cyc(); chk("rel_decode", state, 1); chk("rel_ret2", instr_ret, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
